// File: rtl/tl_a_arbiter.sv
// -----------------------------------------------------------------------------
// tl_a_arbiter
// Round-robin arbiter for the TileLink A channel. It picks one of n requesters,
// drives the one-hot select of the downstream bundle mux, and owns the
// valid/ready handshake. A multi-beat message holds the grant until its last
// beat, so beats from different sources never interleave.
//
// Ports
//   i_clock       : sole clock, rising edge
//   i_reset_n     : asynchronous active-low reset
//   i_in_valid    : [n]        requester i presents a beat
//   i_in_beats    : [n*beatw]  per requester, beats in message minus 1
//                              (field i at [i*beatw +: beatw], first beat only)
//   o_in_ready    : [n]        beat of requester i accepted this cycle
//   i_out_ready   : downstream A channel ready
//   o_out_valid   : selected requester's beat is valid
//   o_select      : [n]        one-hot (or all-zero) bundle-mux select
//   o_out_first   : current beat is the first of its message
//   o_out_last    : current beat is the last of its message
// -----------------------------------------------------------------------------
module tl_a_arbiter #(
    parameter int unsigned n     = 4,
    parameter int unsigned beatw = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [n-1:0]         i_in_valid,
    input  logic [n*beatw-1:0]   i_in_beats,
    output logic [n-1:0]         o_in_ready,
    input  logic                 i_out_ready,
    output logic                 o_out_valid,
    output logic [n-1:0]         o_select,
    output logic                 o_out_first,
    output logic                 o_out_last
);

    localparam int unsigned PW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } mode_t;

    mode_t             r_mode;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_owner;
    logic [beatw-1:0]  r_rem;

    logic              w_found;
    logic [PW-1:0]     w_gnt;
    logic [31:0]       w_scan;
    logic [beatw-1:0]  w_gnt_beats;
    logic              w_hs;

    function automatic logic [n-1:0] onehot(input logic [PW-1:0] idx);
        logic [n-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == PW'(n - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Scan starting at r_ptr and wrapping mod n; the first valid wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_scan  = '0;
        for (int unsigned k = 0; k < n; k++) begin
            w_scan = (32'(r_ptr) + k) % n;
            if (!w_found && i_in_valid[w_scan[PW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_scan[PW-1:0];
            end
        end
    end

    assign w_gnt_beats = i_in_beats[w_gnt*beatw +: beatw];

    always_comb begin
        o_select    = '0;
        o_out_valid = 1'b0;
        o_out_first = 1'b0;
        o_out_last  = 1'b0;
        if (r_mode == IDLE) begin
            o_select    = w_found ? onehot(w_gnt) : '0;
            o_out_valid = |i_in_valid;
            o_out_first = 1'b1;
            o_out_last  = (w_gnt_beats == '0);
        end else begin
            // Locked: other requesters are invisible until the burst ends.
            o_select    = onehot(r_owner);
            o_out_valid = i_in_valid[r_owner];
            o_out_first = 1'b0;
            o_out_last  = (r_rem == beatw'(1));
        end
    end

    assign w_hs       = o_out_valid & i_out_ready;
    assign o_in_ready = o_select & {n{w_hs}};

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mode  <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_rem   <= '0;
        end else if (w_hs) begin
            if (r_mode == IDLE) begin
                if (w_gnt_beats == '0) begin
                    r_ptr <= next_idx(w_gnt);
                end else begin
                    r_mode  <= LOCK;
                    r_owner <= w_gnt;
                    r_rem   <= w_gnt_beats;
                end
            end else begin
                r_rem <= r_rem - 1'b1;
                if (r_rem == beatw'(1)) begin
                    r_mode <= IDLE;
                    r_ptr  <= next_idx(r_owner);
                end
            end
        end
    end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tl_a_arbiter
// Directed bench for tl_a_arbiter (n=4, beatw=4). Stimulus pushes the expected
// beat (select/first/last) into a queue; a monitor pops and compares on every
// handshake. Stall, backpressure and reset conditions are checked directly.
// -----------------------------------------------------------------------------
module tb_tl_a_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned BW = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*BW-1:0] in_beats;
    logic [N-1:0]    in_ready;
    logic            out_ready;
    logic            out_valid;
    logic [N-1:0]    sel;
    logic            out_first;
    logic            out_last;

    typedef struct packed {
        logic [N-1:0] sel;
        logic         first;
        logic         last;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    tl_a_arbiter #(.n(N), .beatw(BW)) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_in_valid  (in_valid),
        .i_in_beats  (in_beats),
        .o_in_ready  (in_ready),
        .i_out_ready (out_ready),
        .o_out_valid (out_valid),
        .o_select    (sel),
        .o_out_first (out_first),
        .o_out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beats(input int unsigned i, input logic [BW-1:0] v);
        in_beats[i*BW +: BW] = v;
    endtask

    task automatic push(input logic [N-1:0] s, input logic f, input logic l);
        exp_t e;
        e.sel = s; e.first = f; e.last = l;
        q.push_back(e);
    endtask

    // Monitor: every accepted beat must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", {28'd0, sel}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("beat_select", {28'd0, sel},      {28'd0, e.sel});
                chk("beat_first",  {31'd0, out_first}, {31'd0, e.first});
                chk("beat_last",   {31'd0, out_last},  {31'd0, e.last});
                chk("beat_ready",  {28'd0, in_ready},  {28'd0, e.sel});
            end
        end
    end

    initial begin
        // Reset held: IDLE rules with ptr=0.
        rst_n     = 1'b0;
        in_valid  = 4'b1010;
        in_beats  = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_select", {28'd0, sel}, 32'h2);
        chk("rst_first",  {31'd0, out_first}, 32'd1);
        chk("rst_valid",  {31'd0, out_valid}, 32'd1);
        chk("rst_ready",  {28'd0, in_ready}, 32'd0);
        cyc();
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push(4'b0010, 1, 1); push(4'b1000, 1, 1);
        push(4'b0010, 1, 1); push(4'b1000, 1, 1);
        repeat (4) cyc();
        in_valid = '0;
        cyc();

        // Round robin over all four (ptr=0).
        in_valid = 4'b1111;
        push(4'b0001, 1, 1); push(4'b0010, 1, 1); push(4'b0100, 1, 1);
        push(4'b1000, 1, 1); push(4'b0001, 1, 1);
        repeat (5) cyc();
        in_valid = '0;
        cyc();

        // ptr=1: a single req1 beat moves ptr to 2.
        in_valid = 4'b0010;
        push(4'b0010, 1, 1);
        cyc();

        // Burst lock: req2 four beats, req0 waits.
        in_valid = 4'b0101;
        set_beats(2, 4'd3);
        push(4'b0100, 1, 0); push(4'b0100, 0, 0); push(4'b0100, 0, 0);
        push(4'b0100, 0, 1); push(4'b0001, 1, 1);
        repeat (5) cyc();
        in_valid = '0;
        cyc();

        // ptr=1 again -> 2.
        in_valid = 4'b0010;
        push(4'b0010, 1, 1);
        cyc();

        // Owner stall at rem=2; a late change to in_beats[2] must be ignored.
        in_valid = 4'b0101;
        push(4'b0100, 1, 0); push(4'b0100, 0, 0);
        repeat (2) cyc();
        in_valid = 4'b0001;
        set_beats(2, 4'd7);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid",  {31'd0, out_valid}, 32'd0);
            chk("stall_select", {28'd0, sel}, 32'h4);
            chk("stall_ready",  {28'd0, in_ready}, 32'd0);
            cyc();
        end
        in_valid = 4'b0101;
        push(4'b0100, 0, 0); push(4'b0100, 0, 1); push(4'b0001, 1, 1);
        repeat (3) cyc();
        in_valid = '0;
        set_beats(2, 4'd0);
        cyc();

        // Backpressure with ptr=1.
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready",  {28'd0, in_ready}, 32'd0);
            chk("bp_select", {28'd0, sel}, 32'h2);
            chk("bp_first",  {31'd0, out_first}, 32'd1);
            cyc();
        end
        out_ready = 1'b1;
        push(4'b0010, 1, 1);
        cyc();
        in_valid = '0;
        cyc();

        // Async reset mid-burst (ptr=2, rem=2).
        in_valid = 4'b0100;
        set_beats(2, 4'd3);
        push(4'b0100, 1, 0); push(4'b0100, 0, 0);
        repeat (2) cyc();
        out_ready = 1'b0;
        #1;
        chk("lock_first", {31'd0, out_first}, 32'd0);
        rst_n    = 1'b0;
        in_valid = 4'b1001;
        #1;
        chk("arst_select", {28'd0, sel}, 32'h1);
        chk("arst_first",  {31'd0, out_first}, 32'd1);
        cyc();
        rst_n = 1'b1;
        set_beats(2, 4'd0);
        out_ready = 1'b1;
        push(4'b0001, 1, 1); push(4'b1000, 1, 1);
        repeat (2) cyc();
        in_valid = '0;

        // Drain with a bound.
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        chk("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
